// File: rtl/wb_writeback_unit_if.sv
// MEM/WB -> writeback handshake bundle: one retired instruction per wb_valid & wb_ready.
interface wb_writeback_unit_if #(
  parameter int XLEN   = 32,
  parameter int MLANES = 4,
  parameter int RF_AW  = 5
);
  logic                    wb_valid;
  logic                    wb_ready;
  logic [XLEN-1:0]         wb_mem_data;
  logic [XLEN-1:0]         wb_alu_o;
  logic [XLEN*MLANES-1:0]  wb_matrix_o;
  logic [RF_AW-1:0]        wb_rd;
  logic                    wb_mem2reg;
  logic [1:0]              wb_w_select;

  modport master (
    output wb_valid, wb_mem_data, wb_alu_o, wb_matrix_o, wb_rd, wb_mem2reg, wb_w_select,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, wb_mem_data, wb_alu_o, wb_matrix_o, wb_rd, wb_mem2reg, wb_w_select,
    output wb_ready
  );
endinterface

// File: rtl/wb_writeback_unit.sv
// Writeback stage: scalar results in one RF beat, matrix results drained over MLANES beats.
// Optional macro WB_FWD_EN adds forwarding outputs and a pending-register mask.
module wb_writeback_unit #(
  parameter int XLEN   = 32,
  parameter int MLANES = 4,
  parameter int RF_AW  = 5
) (
  input  logic               clk,
  input  logic               rst,
  wb_writeback_unit_if.slave wb,
  output logic               rf_we,
  output logic [RF_AW-1:0]   rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               wb_busy
`ifdef WB_FWD_EN
  ,
  output logic               fwd_valid,
  output logic [RF_AW-1:0]   fwd_addr,
  output logic [XLEN-1:0]    fwd_data,
  output logic [(1<<RF_AW)-1:0] fwd_pending_mask
`endif
);
  localparam int CW = (MLANES > 1) ? $clog2(MLANES) : 1;

  typedef enum logic {IDLE, MAT} state_t;

  state_t                       state;
  logic [CW-1:0]                cnt;
  logic [MLANES-1:0][XLEN-1:0]  mat_q;
  logic [RF_AW-1:0]             rd_q;

  logic                         xfer;
  logic [MLANES-1:0][XLEN-1:0]  lanes_in;
  logic [XLEN-1:0]              scalar;
  logic [RF_AW-1:0]             beat_addr;

  assign wb.wb_ready = (state == IDLE);
  assign wb_busy     = (state != IDLE);
  assign xfer        = wb.wb_valid & wb.wb_ready;
  assign lanes_in    = wb.wb_matrix_o;
  assign scalar      = wb.wb_mem2reg ? wb.wb_mem_data : wb.wb_alu_o;
  // Address arithmetic is RF_AW wide so rd+cnt wraps modulo the register count.
  assign beat_addr   = rd_q + RF_AW'(cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      mat_q    <= '0;
      rd_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          rf_we <= 1'b0;
          if (xfer) begin
            case (wb.wb_w_select)
              2'd1: begin
                rf_we    <= (wb.wb_rd != '0);
                rf_waddr <= wb.wb_rd;
                rf_wdata <= scalar;
              end
              2'd2: begin
                mat_q    <= lanes_in;
                rd_q     <= wb.wb_rd;
                rf_we    <= (wb.wb_rd != '0);
                rf_waddr <= wb.wb_rd;
                rf_wdata <= lanes_in[0];
                cnt      <= CW'(1);
                state    <= MAT;
              end
              default: ;
            endcase
          end
        end
        MAT: begin
          rf_we    <= (beat_addr != '0);
          rf_waddr <= beat_addr;
          rf_wdata <= mat_q[cnt];
          if (cnt == CW'(MLANES-1)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_FWD_EN
  logic [(1<<RF_AW)-1:0] pend_q, set_mask;

  // Beat 0 is emitted at the transfer edge, so only lanes 1.. are ever pending.
  always_comb begin
    set_mask = '0;
    for (int k = 1; k < MLANES; k++)
      set_mask[wb.wb_rd + RF_AW'(k)] = 1'b1;
    set_mask[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pend_q <= '0;
    else if (state == IDLE && xfer && wb.wb_w_select == 2'd2)
      pend_q <= set_mask;
    else if (state == MAT)
      pend_q[beat_addr] <= 1'b0;
  end

  assign fwd_valid        = rf_we;
  assign fwd_addr         = rf_waddr;
  assign fwd_data         = rf_wdata;
  assign fwd_pending_mask = pend_q;
`endif
endmodule

// File: tb/tb_wb_writeback_unit.sv
// Scoreboard bench: the driver pushes expected RF beats on each accepted transfer,
// a negedge monitor pops one per cycle and compares every rf_* / handshake output.
module tb_wb_writeback_unit;
  logic clk = 1'b0;
  logic rst;
  logic rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic wb_busy;
`ifdef WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic [31:0] fwd_pending_mask;
`endif

  always #5 clk = ~clk;

  wb_writeback_unit_if #(.XLEN(32), .MLANES(4), .RF_AW(5)) bus ();

  wb_writeback_unit #(.XLEN(32), .MLANES(4), .RF_AW(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb       (bus),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .wb_busy  (wb_busy)
`ifdef WB_FWD_EN
    ,
    .fwd_valid        (fwd_valid),
    .fwd_addr         (fwd_addr),
    .fwd_data         (fwd_data),
    .fwd_pending_mask (fwd_pending_mask)
`endif
  );

  typedef struct {
    logic        we;
    logic        upd;   // addr/data outputs take new values this beat
    logic        mat;   // beat belongs to a matrix drain
    logic [4:0]  a;
    logic [31:0] d;
  } beat_t;

  beat_t q[$];
  int    nchk = 0, nerr = 0;
  logic  acc = 1'b0, rst_seen = 1'b0, mon_en = 1'b0;
  logic [4:0]  cur_a;
  logic [31:0] cur_d;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Reference model: a transfer happens whenever no beats are outstanding.
  always @(posedge clk) begin
    beat_t b;
    if (rst) begin
      q.delete();
      rst_seen = 1'b1;
      mon_en   = 1'b1;
      acc      = 1'b0;
    end else begin
      acc = bus.wb_valid && (q.size() == 0);
      if (acc) begin
        case (bus.wb_w_select)
          2'd1: begin
            b.a = bus.wb_rd; b.we = (bus.wb_rd != 0); b.upd = 1'b1; b.mat = 1'b0;
            b.d = bus.wb_mem2reg ? bus.wb_mem_data : bus.wb_alu_o;
            q.push_back(b);
          end
          2'd2: begin
            for (int k = 0; k < 4; k++) begin
              b.a = 5'((int'(bus.wb_rd) + k) % 32);
              b.we = (b.a != 0); b.upd = 1'b1; b.mat = 1'b1;
              b.d = bus.wb_matrix_o[k*32 +: 32];
              q.push_back(b);
            end
          end
          default: begin
            b.a = '0; b.d = '0; b.we = 1'b0; b.upd = 1'b0; b.mat = 1'b0;
            q.push_back(b);
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    beat_t e;
    logic  exp_we;
    logic [31:0] pm;
    if (mon_en) begin
      if (rst_seen) begin
        cur_a = '0; cur_d = '0; rst_seen = 1'b0;
      end
      exp_we = 1'b0;
      if (q.size() > 0) begin
        e = q.pop_front();
        exp_we = e.we;
        if (e.upd) begin
          cur_a = e.a; cur_d = e.d;
        end
      end
      chk("rf_we",    32'(rf_we),        32'(exp_we));
      chk("rf_waddr", 32'(rf_waddr),     32'(cur_a));
      chk("rf_wdata", rf_wdata,          cur_d);
      chk("wb_ready", 32'(bus.wb_ready), 32'(q.size() == 0));
      chk("wb_busy",  32'(wb_busy),      32'(q.size() != 0));
`ifdef WB_FWD_EN
      pm = '0;
      foreach (q[i]) if (q[i].mat && q[i].a != 0) pm[q[i].a] = 1'b1;
      chk("fwd_pending_mask", fwd_pending_mask, pm);
      chk("fwd_valid", 32'(fwd_valid), 32'(exp_we));
      chk("fwd_addr",  32'(fwd_addr),  32'(cur_a));
      chk("fwd_data",  fwd_data,       cur_d);
`endif
    end
  end

  task automatic send(input logic [1:0] sel, input logic [4:0] rd, input logic m2r,
                      input logic [31:0] mem, input logic [31:0] alu, input logic [127:0] mat);
    int n = 0;
    bus.wb_valid    = 1'b1;
    bus.wb_w_select = sel;
    bus.wb_rd       = rd;
    bus.wb_mem2reg  = m2r;
    bus.wb_mem_data = mem;
    bus.wb_alu_o    = alu;
    bus.wb_matrix_o = mat;
    do begin
      @(posedge clk); #1; n++;
    end while (!acc && n < 50);
    if (!acc) begin
      nchk++; nerr++;
      $display("FAIL accept_timeout: got no transfer expected one within 50 cycles");
    end
    bus.wb_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.wb_valid = 1'b0; bus.wb_w_select = '0; bus.wb_rd = '0; bus.wb_mem2reg = 1'b0;
    bus.wb_mem_data = '0; bus.wb_alu_o = '0; bus.wb_matrix_o = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    send(2'd1, 5'd5, 1'b0, 32'h0, 32'hDEADBEEF, '0);
    send(2'd1, 5'd7, 1'b1, 32'h12345678, 32'hFFFFFFFF, '0);
    send(2'd0, 5'd9, 1'b0, 32'h0, 32'hCAFEF00D, '0);
    idle(2);
    send(2'd2, 5'd8, 1'b0, 32'h0, 32'h0, 128'h44444444_33333333_22222222_11111111);
    send(2'd1, 5'd3, 1'b0, 32'h0, 32'hAAAA5555, '0);
    idle(2);
    send(2'd2, 5'd30, 1'b0, 32'h0, 32'h0, 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000);
    send(2'd1, 5'd0, 1'b0, 32'h0, 32'h0BAD0BAD, '0);
    send(2'd3, 5'd6, 1'b1, 32'h77777777, 32'h0, '0);
    idle(2);

    send(2'd2, 5'd4, 1'b0, 32'h0, 32'h0, 128'h40404040_30303030_20202020_10101010);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    send(2'd1, 5'd17, 1'b1, 32'h5A5A1234, 32'h0, '0);
    idle(2);

    send(2'd2, 5'd12, 1'b0, 32'h0, 32'h0, 128'hF4F4F4F4_F3F3F3F3_F2F2F2F2_F1F1F1F1);
    idle(5);

    for (int i = 0; i < 200; i++) begin
      send(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 1'($urandom),
           $urandom, $urandom, {$urandom, $urandom, $urandom, $urandom});
      idle(int'($urandom_range(0, 2)));
    end
    idle(6);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/wb_writeback_unit.md
Name: wb_writeback_unit

Overview:
Writeback stage at the consumer end of the MEM/WB pipeline register. It accepts one retired instruction per handshake and turns it into 32-bit register-file write beats.
- Scalar results: one beat, selected between load data and ALU result.
- 128-bit matrix results: four consecutive beats to rd..rd+3, with upstream back-pressure while draining.
- Sits between the MEM/WB register and the integer register file write port.

Parameters:
XLEN, 32, scalar data / register-file write width
MLANES, 4, 32-bit lanes per matrix result (matrix width = XLEN*MLANES = 128)
RF_AW, 5, register-file address width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
wb_valid  input  1  MEM/WB holds a valid instruction
wb_ready  output  1  unit can accept this cycle; transfer = wb_valid & wb_ready
wb_mem_data  input  32  load data
wb_alu_o  input  32  ALU result
wb_matrix_o  input  128  matrix result; lane k = bits [32k+31:32k]
wb_rd  input  5  destination register (matrix: base register)
wb_mem2reg  input  1  scalar source select: 1 = wb_mem_data, 0 = wb_alu_o
wb_w_select  input  2  0 = no write, 1 = scalar write, 2 = matrix write, 3 = reserved (no write)
rf_we  output  1  register-file write enable
rf_waddr  output  5  register-file write address
rf_wdata  output  32  register-file write data
wb_busy  output  1  matrix drain in progress (= ~wb_ready)

Behaviour:
Reset:
- rst=1 at a clock edge forces state IDLE, beat counter 0, rf_we=0, rf_waddr=0, rf_wdata=0, latched matrix/rd cleared.
- wb_ready=1 in the first cycle after reset.
- Reset mid-drain abandons the remaining beats; no further rf_we pulses.

FSM states: IDLE, MAT.
- wb_ready = (state==IDLE); purely combinational from state.

IDLE, transfer at cycle T:
- w_select=1: at T+1 rf_we=1, rf_waddr=wb_rd, rf_wdata = mem2reg ? mem_data : alu_o. State stays IDLE.
- w_select=0 or 3: at T+1 rf_we=0; address/data outputs hold their previous values.
- w_select=2:
  - Latch lanes 1..3 and wb_rd.
  - At T+1 emit beat 0: rf_waddr=rd, rf_wdata=lane0.
  - State becomes MAT with cnt=1.
- No transfer: rf_we=0 next cycle.

MAT:
- Each cycle emit beat cnt at the next edge: rf_waddr = (rd+cnt) mod 32, rf_wdata = lane cnt; then cnt++.
- After beat MLANES-1 is emitted, return to IDLE.
- Beats appear at T+1..T+4; wb_ready=0 during T+1..T+3 and 1 at T+4.
- A new transfer at T+4 produces its first write at T+5 (no bubble).

x0 handling:
- Any beat whose address is 0 is emitted with rf_we=0 (the beat slot is still consumed).
- This also applies after wrap-around, e.g. rd=30 writes 30, 31, (0 suppressed), 1.

Other rules:
- wb_valid while wb_ready=0 is ignored; upstream must hold its inputs.
- The unit does not sample them.
- rf_* outputs are registered (one-cycle latency from transfer); no combinational path from inputs to rf_*.

Optional Feature:
Macro WB_FWD_EN.
- Defined: adds outputs fwd_valid (1), fwd_addr (5), fwd_data (32), combinationally equal to rf_we/rf_waddr/rf_wdata.
- Defined: adds output fwd_pending_mask (32). Bit r is set while register r is still scheduled for a matrix beat not yet emitted.
  - Set on the matrix transfer for rd+1..rd+3, excluding x0.
  - Each bit clears in the cycle its beat is emitted.
  - Cleared by reset.
- Not defined: these ports and the mask logic are absent; core behaviour is identical.

Test Plan:
1. Reset → rf_we=0, rf_waddr=0, rf_wdata=0, wb_ready=1; then scalar transfer rd=5, mem2reg=0, alu_o=0xDEADBEEF, w_select=1 → next cycle rf_we=1, addr=5, data=0xDEADBEEF.
2. Load path: rd=7, mem2reg=1, mem_data=0x12345678, alu_o=0xFFFFFFFF → addr=7, data=0x12345678; w_select=0 transfer → rf_we=0.
3. Matrix: rd=8, matrix_o=0x44444444_33333333_22222222_11111111 → beats addr 8..11, data 0x11111111, 0x22222222, 0x33333333, 0x44444444 on 4 consecutive cycles. wb_ready low for 3 cycles; a back-to-back scalar held on wb_valid writes in the 5th cycle.
4. Wrap/x0: matrix rd=30 → writes to 30, 31, then one slot with rf_we=0, then 1; rd=0 scalar → rf_we=0.
5. Reset asserted during beat 2 of a matrix drain → no further rf_we; wb_ready=1 next cycle; later scalar write correct.
6. WB_FWD_EN: matrix rd=12 → fwd_pending_mask=0x0000E000 after transfer, clearing bits 13, 14, 15 in successive cycles; fwd_* mirrors rf_*.
